// File: rtl/servo_motion_sequencer.sv
// rtl/servo_motion_sequencer.sv - rate-limited x/y/z pose slewing sequencer with settle and done
// Optional SEQ_HOME_EN adds a home input that slews every axis back to RESET_ANGLE.
module servo_motion_sequencer #(
    parameter int FREQ         = 25_000_000,
    parameter int UPDATE_HZ    = 50,
    parameter int STEP_DEG     = 2,
    parameter int SETTLE_TICKS = 5,
    parameter int BIT_SIZE     = 11,
    parameter int COORD_LIM    = 270,
    parameter int RESET_ANGLE  = 90
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic signed [BIT_SIZE-1:0] cmd_x,
    input  logic signed [BIT_SIZE-1:0] cmd_y,
    input  logic signed [BIT_SIZE-1:0] cmd_z,
    input  logic                       abort,
`ifdef SEQ_HOME_EN
    input  logic                       home,
`endif
    output logic signed [BIT_SIZE-1:0] x,
    output logic signed [BIT_SIZE-1:0] y,
    output logic signed [BIT_SIZE-1:0] z,
    output logic                       busy,
    output logic                       done
);
    localparam int TICK_DIV = FREQ / UPDATE_HZ;
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int SW = $clog2(SETTLE_TICKS + 1);
    localparam logic signed [BIT_SIZE-1:0] LIM_P  = BIT_SIZE'(COORD_LIM);
    localparam logic signed [BIT_SIZE-1:0] LIM_N  = BIT_SIZE'(-COORD_LIM);
    localparam logic signed [BIT_SIZE-1:0] CENTRE = BIT_SIZE'(RESET_ANGLE);
    localparam logic signed [BIT_SIZE-1:0] STEP_B = BIT_SIZE'(STEP_DEG);
    localparam logic signed [BIT_SIZE:0]   STEP_W = (BIT_SIZE+1)'(STEP_DEG);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SETTLE, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [TW-1:0]              cnt_q, cnt_d;
    logic [SW-1:0]              settle_q, settle_d;
    logic signed [BIT_SIZE-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [BIT_SIZE-1:0] tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
    logic                       ready_q, busy_q, done_q;
    logic                       tick, at_tgt, go_home;

    function automatic logic signed [BIT_SIZE-1:0] clamp(input logic signed [BIT_SIZE-1:0] v);
        if (v > LIM_P)      return LIM_P;
        else if (v < LIM_N) return LIM_N;
        else                return v;
    endfunction

    // Difference taken one bit wider so a full-range swing cannot wrap.
    function automatic logic signed [BIT_SIZE-1:0] slew(input logic signed [BIT_SIZE-1:0] cur,
                                                        input logic signed [BIT_SIZE-1:0] tgt);
        logic signed [BIT_SIZE:0] d;
        d = $signed({tgt[BIT_SIZE-1], tgt}) - $signed({cur[BIT_SIZE-1], cur});
        if (d <= STEP_W && d >= -STEP_W) return tgt;
        else if (d > 0)                  return cur + STEP_B;
        else                             return cur - STEP_B;
    endfunction

`ifdef SEQ_HOME_EN
    assign go_home = home;
`else
    assign go_home = 1'b0;
`endif

    assign tick   = (cnt_q == TW'(TICK_DIV - 1));
    assign at_tgt = (x_q == tx_q) && (y_q == ty_q) && (z_q == tz_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        x_d = x_q;  y_d = y_q;  z_d = z_q;
        tx_d = tx_q; ty_d = ty_q; tz_d = tz_q;
        case (state_q)
            S_IDLE: begin
                if (go_home) begin
                    tx_d = CENTRE; ty_d = CENTRE; tz_d = CENTRE;
                    cnt_d = '0;
                    state_d = S_MOVE;
                end else if (cmd_valid) begin
                    tx_d = clamp(cmd_x); ty_d = clamp(cmd_y); tz_d = clamp(cmd_z);
                    cnt_d = '0;
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (abort) begin
                    tx_d = x_q; ty_d = y_q; tz_d = z_q;
                    state_d = S_IDLE;
                end else if (at_tgt) begin
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end else if (tick) begin
                    x_d = slew(x_q, tx_q);
                    y_d = slew(y_q, ty_q);
                    z_d = slew(z_q, tz_q);
                end
            end
            S_SETTLE: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (abort) begin
                    tx_d = x_q; ty_d = y_q; tz_d = z_q;
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (settle_q == SW'(SETTLE_TICKS - 1)) state_d = S_DONE;
                    else                                   settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            x_q <= CENTRE;  y_q <= CENTRE;  z_q <= CENTRE;
            tx_q <= CENTRE; ty_q <= CENTRE; tz_q <= CENTRE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            x_q <= x_d;  y_q <= y_d;  z_q <= z_d;
            tx_q <= tx_d; ty_q <= ty_d; tz_q <= tz_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d == S_MOVE) || (state_d == S_SETTLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// tb/tb_servo_motion_sequencer.sv - directed self-checking bench for servo_motion_sequencer
module tb_servo_motion_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid = 1'b0;
    logic abort = 1'b0;
    logic signed [10:0] cmd_x = '0, cmd_y = '0, cmd_z = '0;
    logic signed [10:0] x, y, z;
    logic cmd_ready, busy, done;
`ifdef SEQ_HOME_EN
    logic home = 1'b0;
`endif
    int total = 0;
    int bad = 0;

    servo_motion_sequencer #(
        .FREQ(1000), .UPDATE_HZ(100), .STEP_DEG(2), .SETTLE_TICKS(5),
        .BIT_SIZE(11), .COORD_LIM(270), .RESET_ANGLE(90)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .abort(abort),
`ifdef SEQ_HOME_EN
        .home(home),
`endif
        .x(x), .y(y), .z(z), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    // Presents one command for one edge; returns just after the accepting edge.
    task automatic send(input int cx, input int cy, input int cz);
        cmd_x = 11'(cx); cmd_y = 11'(cy); cmd_z = 11'(cz);
        cmd_valid = 1'b1;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        total++; if (x !== 90 || y !== 90 || z !== 90) begin bad++; $display("FAIL reset_pos got %0d %0d %0d want 90 90 90", x, y, z); end
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags got rdy=%b busy=%b done=%b want 1 0 0", cmd_ready, busy, done); end
        send(100, 80, 90);
        step(25);
        total++; if (x !== 94) begin bad++; $display("FAIL reset_premove_x got %0d want 94", x); end
        rst = 1'b0;
        step(1);
        total++; if (x !== 90 || y !== 90 || z !== 90) begin bad++; $display("FAIL reset_midmove_pos got %0d %0d %0d want 90 90 90", x, y, z); end
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_midmove_flags got busy=%b rdy=%b want 0 1", busy, cmd_ready); end
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_normal_move();
        int cyc;
        do_reset();
        send(100, 80, 90);
        total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL move_accept got busy=%b rdy=%b want 1 0", busy, cmd_ready); end
        for (int k = 1; k <= 5; k++) begin
            step(9);
            total++; if (x !== 90 + 2*(k-1)) begin bad++; $display("FAIL move_hold_x%0d got %0d want %0d", k, x, 90 + 2*(k-1)); end
            step(1);
            total++; if (x !== 90 + 2*k || y !== 90 - 2*k || z !== 90) begin bad++; $display("FAIL move_tick%0d got %0d %0d %0d want %0d %0d 90", k, x, y, z, 90 + 2*k, 90 - 2*k); end
        end
        wait_done(200, cyc);
        total++; if (cyc !== 50) begin bad++; $display("FAIL move_done_time got %0d want 50", cyc); end
        step(1);
        total++; if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL move_after_done got done=%b rdy=%b busy=%b want 0 1 0", done, cmd_ready, busy); end
    endtask

    task automatic test_clamp();
        int cyc;
        do_reset();
        send(500, -300, 95);
        step(10);
        total++; if (x !== 92 || y !== 88 || z !== 92) begin bad++; $display("FAIL clamp_t1 got %0d %0d %0d want 92 88 92", x, y, z); end
        step(10);
        total++; if (z !== 94) begin bad++; $display("FAIL clamp_z2 got %0d want 94", z); end
        step(10);
        total++; if (x !== 96 || y !== 84 || z !== 95) begin bad++; $display("FAIL clamp_t3 got %0d %0d %0d want 96 84 95", x, y, z); end
        step(860);
        total++; if (x !== 268) begin bad++; $display("FAIL clamp_x89 got %0d want 268", x); end
        step(10);
        total++; if (x !== 270 || y !== -90) begin bad++; $display("FAIL clamp_x90 got %0d %0d want 270 -90", x, y); end
        step(890);
        total++; if (y !== -268 || x !== 270) begin bad++; $display("FAIL clamp_y179 got %0d %0d want 270 -268", x, y); end
        step(10);
        total++; if (y !== -270 || z !== 95) begin bad++; $display("FAIL clamp_y180 got %0d %0d want -270 95", y, z); end
        wait_done(200, cyc);
        total++; if (cyc !== 50) begin bad++; $display("FAIL clamp_done_time got %0d want 50", cyc); end
        step(1);
    endtask

    task automatic test_abort();
        do_reset();
        send(100, 80, 90);
        step(29);
        total++; if (x !== 94 || y !== 86) begin bad++; $display("FAIL abort_pre got %0d %0d want 94 86", x, y); end
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        total++; if (x !== 94 || y !== 86 || z !== 90) begin bad++; $display("FAIL abort_hold got %0d %0d %0d want 94 86 90", x, y, z); end
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL abort_flags got busy=%b rdy=%b done=%b want 0 1 0", busy, cmd_ready, done); end
        send(80, 100, 90);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_reaccept got busy=%b want 1", busy); end
        step(10);
        total++; if (x !== 92 || y !== 88) begin bad++; $display("FAIL abort_newmove got %0d %0d want 92 88", x, y); end
    endtask

    task automatic test_zero_backpressure();
        int cyc;
        do_reset();
        send(90, 90, 90);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_accept got busy=%b want 1", busy); end
        step(4);
        cmd_x = 11'(0); cmd_y = 11'(0); cmd_z = 11'(0);
        cmd_valid = 1'b1;
        step(3);
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL zero_busy got rdy=%b busy=%b want 0 1", cmd_ready, busy); end
        wait_done(200, cyc);
        total++; if (cyc !== 43) begin bad++; $display("FAIL zero_done_time got %0d want 43", cyc); end
        total++; if (x !== 90 || y !== 90 || z !== 90) begin bad++; $display("FAIL zero_pos got %0d %0d %0d want 90 90 90", x, y, z); end
        step(1);
        total++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL zero_idle got rdy=%b done=%b want 1 0", cmd_ready, done); end
        step(20);
        total++; if (x !== 90 || busy !== 1'b0) begin bad++; $display("FAIL zero_ignored got x=%0d busy=%b want 90 0", x, busy); end
    endtask

`ifdef SEQ_HOME_EN
    task automatic test_home();
        int cyc;
        do_reset();
        send(120, 60, -30);
        wait_done(1000, cyc);
        total++; if (cyc !== 650) begin bad++; $display("FAIL home_setup_time got %0d want 650", cyc); end
        step(1);
        total++; if (x !== 120 || y !== 60 || z !== -30) begin bad++; $display("FAIL home_setup_pos got %0d %0d %0d want 120 60 -30", x, y, z); end
        cmd_x = '0; cmd_y = '0; cmd_z = '0;
        home = 1'b1; cmd_valid = 1'b1;
        step(1);
        home = 1'b0; cmd_valid = 1'b0;
        total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL home_accept got busy=%b rdy=%b want 1 0", busy, cmd_ready); end
        step(10);
        total++; if (x !== 118 || y !== 62 || z !== -28) begin bad++; $display("FAIL home_tick1 got %0d %0d %0d want 118 62 -28", x, y, z); end
        wait_done(1000, cyc);
        total++; if (cyc !== 640) begin bad++; $display("FAIL home_done_time got %0d want 640", cyc); end
        total++; if (x !== 90 || y !== 90 || z !== 90) begin bad++; $display("FAIL home_pos got %0d %0d %0d want 90 90 90", x, y, z); end
        step(1);
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL home_idle got rdy=%b busy=%b want 1 0", cmd_ready, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_normal_move();
        test_clamp();
        test_abort();
        test_zero_backpressure();
`ifdef SEQ_HOME_EN
        test_home();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/servo_motion_sequencer.md
Name: servo_motion_sequencer

Overview:
Rate-limited motion controller that sits upstream of the three-servo PWM generator. It accepts one target pose per handshake, as signed x/y/z angles in degrees. It then slews its x/y/z outputs toward that pose by a fixed step on each update tick, so the servos never see step jumps. After the move it holds a settle interval and then signals completion. Its x/y/z outputs connect directly to the PWM generator's coordinate inputs.

Parameters:
FREQ, 25_000_000, system clock frequency in Hz
UPDATE_HZ, 50, slew update rate; TICK_DIV = FREQ/UPDATE_HZ clock cycles per tick
STEP_DEG, 2, maximum per-axis change per tick, in degrees (>=1)
SETTLE_TICKS, 5, ticks to hold after the target is reached, before done
BIT_SIZE, 11, width of the signed angle buses
COORD_LIM, 270, symmetric clamp limit, in degrees
RESET_ANGLE, 90, per-axis position after reset (mechanical centre)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
cmd_valid  in  1  target pose valid
cmd_ready  out  1  sequencer can accept a pose
cmd_x, cmd_y, cmd_z  in  BIT_SIZE signed  target angles
abort  in  1  stop the current motion and hold the present position
x, y, z  out  BIT_SIZE signed  current commanded angles, sent to the PWM generator
busy  out  1  high in MOVE or SETTLE
done  out  1  one-cycle pulse when a move completes

Behaviour:
- One clock: clk. Reset: rst sampled on the rising edge, low = reset.
- Reset values:
  - x = y = z = RESET_ANGLE
  - state = IDLE, cmd_ready = 1, busy = 0, done = 0
  - tick and settle counters = 0, targets = RESET_ANGLE
- Reset asserted mid-move returns all of these values on the next edge.
- States: IDLE, MOVE, SETTLE, DONE. All outputs are registered.
- cmd_ready = (state == IDLE).
- Command acceptance (cmd_valid && cmd_ready):
  - Captures the targets, each clamped to [-COORD_LIM, +COORD_LIM].
  - Clears the tick counter and moves to MOVE.
  - cmd_valid outside IDLE is ignored; no queuing.
- Tick generation:
  - The tick counter runs only in MOVE and SETTLE, counting 0..TICK_DIV-1.
  - tick is high for one cycle when the counter equals TICK_DIV-1; the counter then wraps to 0.
- MOVE, on each tick, per axis:
  - d = tgt - cur, computed signed at BIT_SIZE+1 bits; no overflow is allowed.
  - If |d| <= STEP_DEG: cur = tgt.
  - Otherwise: cur = cur + STEP_DEG*sign(d).
  - All three axes update on the same edge.
- MOVE exit: when all three axes equal their targets (checked every cycle, not only on ticks), go to SETTLE and clear the settle counter.
  - A zero-distance command therefore enters SETTLE on the cycle after acceptance, with no output change.
- SETTLE:
  - Counts ticks. When SETTLE_TICKS ticks have elapsed, go to DONE.
  - Outputs hold.
- DONE:
  - done = 1 for exactly one cycle.
  - Next state is IDLE.
- abort:
  - In MOVE or SETTLE: next state is IDLE and x/y/z hold their present values.
  - The targets are overwritten with the present position, and done is not pulsed.
  - abort has priority over a simultaneous tick or a simultaneous completion.
  - In IDLE or DONE, abort is ignored; the DONE pulse still occurs.
- Outputs never exceed ±COORD_LIM, and are never more than STEP_DEG away from the previous tick's value.

Optional Feature:
Macro SEQ_HOME_EN.
- Defined: adds input port home (1 bit).
  - home = 1 in IDLE: accepted like a command with target (RESET_ANGLE, RESET_ANGLE, RESET_ANGLE), including the same slew, settle and done sequence.
  - If home and cmd_valid are both high in IDLE, home wins and the command is not accepted (cmd_ready drops).
  - home outside IDLE is ignored.
- Undefined: no home port. The only way back to centre is an explicit command.

Test Plan:
Bench parameters: FREQ=1000, UPDATE_HZ=100 (TICK_DIV=10), STEP_DEG=2, SETTLE_TICKS=5.
1. Reset: hold rst=0 for 3 cycles, then release -> x=y=z=90, cmd_ready=1, busy=0, done=0. Then assert rst=0 during MOVE -> x/y/z return to 90 on the next edge.
2. Normal move: command (100, 80, 90).
   - x steps 92, 94, 96, 98, 100; y steps 88, 86, 84, 82, 80; z constant. One step every 10 cycles.
   - 5 ticks in SETTLE follow.
   - done is a single-cycle pulse about 100 cycles after acceptance; cmd_ready returns to 1 the next cycle.
3. Clamp and remainder: command (500, -300, 95) from (90, 90, 90).
   - Targets are 270, -270, 95.
   - z goes 92, 94, 95.
   - x reaches 270 after 90 ticks; y reaches -270 after 180 ticks.
4. Abort: abort=1 on the cycle of the 3rd tick of the test 2 move.
   - x stays at 94 (the tick update is suppressed), state goes to IDLE, no done pulse.
   - A new command is accepted on the next cycle.
5. Zero-distance and back-pressure: command equal to the current pose -> no output change, SETTLE entered immediately, done after 5 ticks. Further cmd_valid pulses during busy are ignored, and the targets are unchanged.
6. SEQ_HOME_EN: from (120, 60, -30), pulse home together with cmd_valid (0, 0, 0).
   - The home target wins and every axis slews to 90 at 2°/tick.
   - The simultaneous command is never accepted.
